scariv_alu_wakeup_pipe: RTL and testbench
=========================================

# scariv_alu_wakeup_pipe

Fixed-latency ALU execution pipe on the producer side of the scheduler wakeup protocol. It accepts one picked instruction per cycle from the ALU issue queue and runs it through three stages (EX0/EX1/EX2). It drives the early-release broadcast consumed by issue entries for speculative `predict_ready`, then the physical-register write broadcast and ROB completion. Branch and commit flushes kill in-flight ops so that no killed op writes back.

## Interface
Parameters:
- `DATA_W`, 64, operand/result width (power of 2)
- `RNID_W`, 7, physical register id width
- `CMT_ID_W`, 6, commit id width; MSB is the wrap bit
- `GRP_W`, 4, one-hot group id width

Ports:
- `i_clk` in 1, clock
- `i_reset_n` in 1, asynchronous active-low reset
- `i_issue_valid` in 1, picked instruction present this cycle
- `i_issue_op` in 3, 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT (signed)
- `i_issue_wr_valid` in 1, instruction has a destination register
- `i_issue_rnid` in RNID_W, destination rnid
- `i_issue_typ` in 1, destination type (0 GPR, 1 FPR)
- `i_issue_cmt_id` in CMT_ID_W, commit id
- `i_issue_grp_id` in GRP_W, group id
- `i_rs1_data`, `i_rs2_data` in DATA_W, operands
- `i_commit_flush` in 1, kill everything in flight
- `i_br_flush` in 1, branch mispredict kill request
- `i_br_cmt_id` in CMT_ID_W, mispredicting branch commit id
- `i_br_grp_id` in GRP_W, mispredicting branch group id
- `o_early_wr_valid` out 1, early wakeup broadcast
- `o_early_wr_rnid` out RNID_W, early wakeup rnid
- `o_early_wr_typ` out 1, early wakeup type
- `o_early_wr_may_mispred` out 1, constant 0 (ALU never speculates)
- `o_phy_wr_valid` out 1, register write broadcast
- `o_phy_wr_rnid` out RNID_W, register write rnid
- `o_phy_wr_typ` out 1, register write type
- `o_phy_wr_data` out DATA_W, register write data
- `o_done_valid` out 1, completion to ROB
- `o_done_cmt_id` out CMT_ID_W, completion commit id
- `o_done_grp_id` out GRP_W, completion group id
- `o_kill_cnt` out 16, saturating count of ops killed in flight

## Operation
- **Stage registers:** EX0, EX1 and EX2 each hold valid, op, wr_valid, rnid, typ, cmt_id and grp_id. EX0 also holds the operands. EX1 and EX2 hold the result.
- **Issue:**
  - An issuing op is captured into EX0 at the edge ending its issue cycle, unless it is killed that cycle.
  - Stages advance every cycle; there is no stall.
- **Compute:**
  - Computed combinationally from EX0 and registered into EX1. EX1 copies to EX2 unchanged.
  - ADD/SUB are modulo 2^DATA_W.
  - Shift amount = `rs2[log2(DATA_W)-1:0]`. SRL is logical.
  - SLT result = 1 if `$signed(rs1) < $signed(rs2)`, else 0, zero-extended.
- **Early wakeup:** `o_early_wr_valid = EX0.valid & EX0.wr_valid & ~kill(EX0)`; rnid and typ come from EX0.
- **Write and completion:**
  - `o_phy_wr_valid = EX2.valid & EX2.wr_valid`, with data, rnid and typ from EX2.
  - `o_done_valid = EX2.valid`, regardless of wr_valid.
- **Kill function for a stage:** `i_commit_flush | (i_br_flush & younger(stage, br))`.
  - If the cmt_id MSBs are equal, the op is younger when its lower cmt bits are greater than the branch's.
  - If the MSBs differ, the op is younger when its lower cmt bits are less than the branch's.
  - If cmt_id is equal, the op is younger when its grp_id is numerically greater than `i_br_grp_id`. The branch itself (equal cmt and grp) is not killed.
- **Applying a kill:**
  - The kill is evaluated on the issue inputs and on EX0, EX1 and EX2 in the same cycle.
  - A killed stage's valid is cleared at the next edge and it does not propagate.
  - A killed EX2 still drives its outputs in the current cycle, because the outputs are registered state. Kill only affects what advances.
- **Kill counter:**
  - `o_kill_cnt` increments by the number of valid ops killed this cycle, counting the issue input plus EX0 and EX1 (max 3).
  - It saturates at 0xFFFF and is cleared only by reset.

## Timing
- Issue in cycle T, then:
  - `o_early_wr` in T+1
  - `o_phy_wr` and `o_done` in T+3
- Early wakeup leads the phy write by exactly 2 cycles. A consumer picked in T+2 via predict_ready receives the data through the bypass at T+3.
- Back-to-back issue gives 1 op/cycle throughput, with all three stages occupied.
- Reset:
  - All stage valids are 0, and all outputs are 0.
  - `o_kill_cnt` = 0.
  - Reset mid-operation discards all in-flight ops, with no writes afterward.
- Simultaneous issue and commit flush: the issuing op is dropped and no early wakeup is produced.
- A branch flush arriving in T+1 may still produce the early wakeup for an older non-killed op; a killed EX0 produces no early wakeup.

## Test plan
- **ADD pipeline:** issue ADD rs1=5, rs2=7, wr_valid=1, rnid=0x12 at T → `o_early_wr_valid`=1 with rnid 0x12 at T+1; `o_phy_wr` data=12, rnid 0x12 and `o_done` at T+3; nothing else.
- **Back-to-back ops:** issue SUB(0,1), SLT(-1,0), SRL(0x8000_0000_0000_0000, 63) on consecutive cycles → phy data 0xFFFF_FFFF_FFFF_FFFF, 1, 1 on consecutive cycles.
- **No destination:** issue with wr_valid=0, cmt_id=3 → no early or phy write; `o_done` with cmt_id 3 at T+3.
- **Branch kill with wrap:** ops cmt_id 0x21 (EX1) and 0x1F (EX0) in flight, branch cmt_id 0x1F grp 0x1 → both younger and killed; no phy/done for either; `o_kill_cnt`=2.
- **Grp-id boundary:** branch cmt_id=4 grp=0x2 flushes; in-flight ops cmt 4/grp 0x1 survives, cmt 4/grp 0x4 is killed, cmt 3/grp 0x8 survives.
- **Commit flush:** commit flush in the same cycle as an issue with 2 ops in flight → no early wakeup for the issuing op, no phy writes for any of the 3; `o_kill_cnt`=3. Assert reset afterwards → all outputs 0, `o_kill_cnt`=0.

Source files
------------

// File: rtl/scariv_alu_wakeup_pipe.sv
// Three-stage ALU execution pipe on the producer side of the scheduler wakeup protocol.
// EX0 drives the early wakeup broadcast; EX2 drives the register write and ROB completion.
module scariv_alu_wakeup_pipe #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned RNID_W   = 7,
  parameter int unsigned CMT_ID_W = 6,
  parameter int unsigned GRP_W    = 4
) (
  input  logic                i_clk,
  input  logic                i_reset_n,

  input  logic                i_issue_valid,
  input  logic [2:0]          i_issue_op,
  input  logic                i_issue_wr_valid,
  input  logic [RNID_W-1:0]   i_issue_rnid,
  input  logic                i_issue_typ,
  input  logic [CMT_ID_W-1:0] i_issue_cmt_id,
  input  logic [GRP_W-1:0]    i_issue_grp_id,
  input  logic [DATA_W-1:0]   i_rs1_data,
  input  logic [DATA_W-1:0]   i_rs2_data,

  input  logic                i_commit_flush,
  input  logic                i_br_flush,
  input  logic [CMT_ID_W-1:0] i_br_cmt_id,
  input  logic [GRP_W-1:0]    i_br_grp_id,

  output logic                o_early_wr_valid,
  output logic [RNID_W-1:0]   o_early_wr_rnid,
  output logic                o_early_wr_typ,
  output logic                o_early_wr_may_mispred,

  output logic                o_phy_wr_valid,
  output logic [RNID_W-1:0]   o_phy_wr_rnid,
  output logic                o_phy_wr_typ,
  output logic [DATA_W-1:0]   o_phy_wr_data,

  output logic                o_done_valid,
  output logic [CMT_ID_W-1:0] o_done_cmt_id,
  output logic [GRP_W-1:0]    o_done_grp_id,

  output logic [15:0]         o_kill_cnt
);

  localparam int unsigned ShamtW = $clog2(DATA_W);

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpAnd = 3'd2;
  localparam logic [2:0] OpOr  = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpSll = 3'd5;
  localparam logic [2:0] OpSrl = 3'd6;
  localparam logic [2:0] OpSlt = 3'd7;

  // EX0 stage
  logic                ex0_valid_q,    ex0_valid_d;
  logic [2:0]          ex0_op_q,       ex0_op_d;
  logic                ex0_wr_valid_q, ex0_wr_valid_d;
  logic [RNID_W-1:0]   ex0_rnid_q,     ex0_rnid_d;
  logic                ex0_typ_q,      ex0_typ_d;
  logic [CMT_ID_W-1:0] ex0_cmt_id_q,   ex0_cmt_id_d;
  logic [GRP_W-1:0]    ex0_grp_id_q,   ex0_grp_id_d;
  logic [DATA_W-1:0]   ex0_rs1_q,      ex0_rs1_d;
  logic [DATA_W-1:0]   ex0_rs2_q,      ex0_rs2_d;

  // EX1 stage
  logic                ex1_valid_q,    ex1_valid_d;
  logic                ex1_wr_valid_q, ex1_wr_valid_d;
  logic [RNID_W-1:0]   ex1_rnid_q,     ex1_rnid_d;
  logic                ex1_typ_q,      ex1_typ_d;
  logic [CMT_ID_W-1:0] ex1_cmt_id_q,   ex1_cmt_id_d;
  logic [GRP_W-1:0]    ex1_grp_id_q,   ex1_grp_id_d;
  logic [DATA_W-1:0]   ex1_result_q,   ex1_result_d;

  // EX2 stage
  logic                ex2_valid_q,    ex2_valid_d;
  logic                ex2_wr_valid_q, ex2_wr_valid_d;
  logic [RNID_W-1:0]   ex2_rnid_q,     ex2_rnid_d;
  logic                ex2_typ_q,      ex2_typ_d;
  logic [CMT_ID_W-1:0] ex2_cmt_id_q,   ex2_cmt_id_d;
  logic [GRP_W-1:0]    ex2_grp_id_q,   ex2_grp_id_d;
  logic [DATA_W-1:0]   ex2_result_q,   ex2_result_d;

  logic [15:0]         kill_cnt_q,     kill_cnt_d;

  logic                kill_issue;
  logic                kill_ex0;
  logic                kill_ex1;
  logic [1:0]          kill_num;
  logic [DATA_W-1:0]   alu_result;
  logic [ShamtW-1:0]   shamt;

  // Commit ids wrap: the MSB flips each lap, so a differing MSB inverts the age comparison.
  function automatic logic is_younger(input logic [CMT_ID_W-1:0] cmt,
                                      input logic [GRP_W-1:0]    grp,
                                      input logic [CMT_ID_W-1:0] br_cmt,
                                      input logic [GRP_W-1:0]    br_grp);
    logic                msb_eq;
    logic [CMT_ID_W-2:0] lo;
    logic [CMT_ID_W-2:0] br_lo;
    msb_eq = (cmt[CMT_ID_W-1] == br_cmt[CMT_ID_W-1]);
    lo     = cmt[CMT_ID_W-2:0];
    br_lo  = br_cmt[CMT_ID_W-2:0];
    if (cmt == br_cmt) begin
      return grp > br_grp;
    end
    return msb_eq ? (lo > br_lo) : (lo < br_lo);
  endfunction

  always_comb begin
    kill_issue = i_commit_flush |
                 (i_br_flush & is_younger(i_issue_cmt_id, i_issue_grp_id,
                                          i_br_cmt_id, i_br_grp_id));
    kill_ex0   = i_commit_flush |
                 (i_br_flush & is_younger(ex0_cmt_id_q, ex0_grp_id_q,
                                          i_br_cmt_id, i_br_grp_id));
    kill_ex1   = i_commit_flush |
                 (i_br_flush & is_younger(ex1_cmt_id_q, ex1_grp_id_q,
                                          i_br_cmt_id, i_br_grp_id));
  end

  always_comb begin
    shamt      = ex0_rs2_q[ShamtW-1:0];
    alu_result = '0;
    unique case (ex0_op_q)
      OpAdd:   alu_result = ex0_rs1_q + ex0_rs2_q;
      OpSub:   alu_result = ex0_rs1_q - ex0_rs2_q;
      OpAnd:   alu_result = ex0_rs1_q & ex0_rs2_q;
      OpOr:    alu_result = ex0_rs1_q | ex0_rs2_q;
      OpXor:   alu_result = ex0_rs1_q ^ ex0_rs2_q;
      OpSll:   alu_result = ex0_rs1_q << shamt;
      OpSrl:   alu_result = ex0_rs1_q >> shamt;
      OpSlt:   alu_result = {{(DATA_W-1){1'b0}},
                             ($signed(ex0_rs1_q) < $signed(ex0_rs2_q))};
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    ex0_valid_d    = i_issue_valid & ~kill_issue;
    ex0_op_d       = i_issue_op;
    ex0_wr_valid_d = i_issue_wr_valid;
    ex0_rnid_d     = i_issue_rnid;
    ex0_typ_d      = i_issue_typ;
    ex0_cmt_id_d   = i_issue_cmt_id;
    ex0_grp_id_d   = i_issue_grp_id;
    ex0_rs1_d      = i_rs1_data;
    ex0_rs2_d      = i_rs2_data;

    ex1_valid_d    = ex0_valid_q & ~kill_ex0;
    ex1_wr_valid_d = ex0_wr_valid_q;
    ex1_rnid_d     = ex0_rnid_q;
    ex1_typ_d      = ex0_typ_q;
    ex1_cmt_id_d   = ex0_cmt_id_q;
    ex1_grp_id_d   = ex0_grp_id_q;
    ex1_result_d   = alu_result;

    ex2_valid_d    = ex1_valid_q & ~kill_ex1;
    ex2_wr_valid_d = ex1_wr_valid_q;
    ex2_rnid_d     = ex1_rnid_q;
    ex2_typ_d      = ex1_typ_q;
    ex2_cmt_id_d   = ex1_cmt_id_q;
    ex2_grp_id_d   = ex1_grp_id_q;
    ex2_result_d   = ex1_result_q;
  end

  // EX2 is not counted: it completes this cycle regardless of the kill.
  always_comb begin
    kill_num = {1'b0, i_issue_valid & kill_issue} +
               {1'b0, ex0_valid_q & kill_ex0} +
               {1'b0, ex1_valid_q & kill_ex1};
    if (kill_cnt_q > (16'hFFFF - {14'd0, kill_num})) begin
      kill_cnt_d = 16'hFFFF;
    end else begin
      kill_cnt_d = kill_cnt_q + {14'd0, kill_num};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ex0_valid_q    <= 1'b0;
      ex0_op_q       <= '0;
      ex0_wr_valid_q <= 1'b0;
      ex0_rnid_q     <= '0;
      ex0_typ_q      <= 1'b0;
      ex0_cmt_id_q   <= '0;
      ex0_grp_id_q   <= '0;
      ex0_rs1_q      <= '0;
      ex0_rs2_q      <= '0;
      ex1_valid_q    <= 1'b0;
      ex1_wr_valid_q <= 1'b0;
      ex1_rnid_q     <= '0;
      ex1_typ_q      <= 1'b0;
      ex1_cmt_id_q   <= '0;
      ex1_grp_id_q   <= '0;
      ex1_result_q   <= '0;
      ex2_valid_q    <= 1'b0;
      ex2_wr_valid_q <= 1'b0;
      ex2_rnid_q     <= '0;
      ex2_typ_q      <= 1'b0;
      ex2_cmt_id_q   <= '0;
      ex2_grp_id_q   <= '0;
      ex2_result_q   <= '0;
      kill_cnt_q     <= '0;
    end else begin
      ex0_valid_q    <= ex0_valid_d;
      ex0_op_q       <= ex0_op_d;
      ex0_wr_valid_q <= ex0_wr_valid_d;
      ex0_rnid_q     <= ex0_rnid_d;
      ex0_typ_q      <= ex0_typ_d;
      ex0_cmt_id_q   <= ex0_cmt_id_d;
      ex0_grp_id_q   <= ex0_grp_id_d;
      ex0_rs1_q      <= ex0_rs1_d;
      ex0_rs2_q      <= ex0_rs2_d;
      ex1_valid_q    <= ex1_valid_d;
      ex1_wr_valid_q <= ex1_wr_valid_d;
      ex1_rnid_q     <= ex1_rnid_d;
      ex1_typ_q      <= ex1_typ_d;
      ex1_cmt_id_q   <= ex1_cmt_id_d;
      ex1_grp_id_q   <= ex1_grp_id_d;
      ex1_result_q   <= ex1_result_d;
      ex2_valid_q    <= ex2_valid_d;
      ex2_wr_valid_q <= ex2_wr_valid_d;
      ex2_rnid_q     <= ex2_rnid_d;
      ex2_typ_q      <= ex2_typ_d;
      ex2_cmt_id_q   <= ex2_cmt_id_d;
      ex2_grp_id_q   <= ex2_grp_id_d;
      ex2_result_q   <= ex2_result_d;
      kill_cnt_q     <= kill_cnt_d;
    end
  end

  assign o_early_wr_valid       = ex0_valid_q & ex0_wr_valid_q & ~kill_ex0;
  assign o_early_wr_rnid        = ex0_rnid_q;
  assign o_early_wr_typ         = ex0_typ_q;
  assign o_early_wr_may_mispred = 1'b0;

  assign o_phy_wr_valid = ex2_valid_q & ex2_wr_valid_q;
  assign o_phy_wr_rnid  = ex2_rnid_q;
  assign o_phy_wr_typ   = ex2_typ_q;
  assign o_phy_wr_data  = ex2_result_q;

  assign o_done_valid  = ex2_valid_q;
  assign o_done_cmt_id = ex2_cmt_id_q;
  assign o_done_grp_id = ex2_grp_id_q;

  assign o_kill_cnt = kill_cnt_q;

endmodule

// File: tb/tb_scariv_alu_wakeup_pipe.sv
// Directed self-checking bench for scariv_alu_wakeup_pipe: pipeline timing, ALU results,
// branch/commit kill behaviour, kill counter and reset.
module tb_scariv_alu_wakeup_pipe;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_issue_valid;
  logic [2:0]  i_issue_op;
  logic        i_issue_wr_valid;
  logic [6:0]  i_issue_rnid;
  logic        i_issue_typ;
  logic [5:0]  i_issue_cmt_id;
  logic [3:0]  i_issue_grp_id;
  logic [63:0] i_rs1_data;
  logic [63:0] i_rs2_data;
  logic        i_commit_flush;
  logic        i_br_flush;
  logic [5:0]  i_br_cmt_id;
  logic [3:0]  i_br_grp_id;
  logic        o_early_wr_valid;
  logic [6:0]  o_early_wr_rnid;
  logic        o_early_wr_typ;
  logic        o_early_wr_may_mispred;
  logic        o_phy_wr_valid;
  logic [6:0]  o_phy_wr_rnid;
  logic        o_phy_wr_typ;
  logic [63:0] o_phy_wr_data;
  logic        o_done_valid;
  logic [5:0]  o_done_cmt_id;
  logic [3:0]  o_done_grp_id;
  logic [15:0] o_kill_cnt;

  int errors = 0;
  int checks = 0;

  scariv_alu_wakeup_pipe dut (
    .i_clk                  (i_clk),
    .i_reset_n              (i_reset_n),
    .i_issue_valid          (i_issue_valid),
    .i_issue_op             (i_issue_op),
    .i_issue_wr_valid       (i_issue_wr_valid),
    .i_issue_rnid           (i_issue_rnid),
    .i_issue_typ            (i_issue_typ),
    .i_issue_cmt_id         (i_issue_cmt_id),
    .i_issue_grp_id         (i_issue_grp_id),
    .i_rs1_data             (i_rs1_data),
    .i_rs2_data             (i_rs2_data),
    .i_commit_flush         (i_commit_flush),
    .i_br_flush             (i_br_flush),
    .i_br_cmt_id            (i_br_cmt_id),
    .i_br_grp_id            (i_br_grp_id),
    .o_early_wr_valid       (o_early_wr_valid),
    .o_early_wr_rnid        (o_early_wr_rnid),
    .o_early_wr_typ         (o_early_wr_typ),
    .o_early_wr_may_mispred (o_early_wr_may_mispred),
    .o_phy_wr_valid         (o_phy_wr_valid),
    .o_phy_wr_rnid          (o_phy_wr_rnid),
    .o_phy_wr_typ           (o_phy_wr_typ),
    .o_phy_wr_data          (o_phy_wr_data),
    .o_done_valid           (o_done_valid),
    .o_done_cmt_id          (o_done_cmt_id),
    .o_done_grp_id          (o_done_grp_id),
    .o_kill_cnt             (o_kill_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Each cycle: tick() moves 1 time unit past the edge, inputs are driven, then #1 to settle.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_issue_valid    = 1'b0;
    i_issue_op       = 3'd0;
    i_issue_wr_valid = 1'b0;
    i_issue_rnid     = 7'd0;
    i_issue_typ      = 1'b0;
    i_issue_cmt_id   = 6'd0;
    i_issue_grp_id   = 4'd0;
    i_rs1_data       = 64'd0;
    i_rs2_data       = 64'd0;
    i_commit_flush   = 1'b0;
    i_br_flush       = 1'b0;
    i_br_cmt_id      = 6'd0;
    i_br_grp_id      = 4'd0;
  endtask

  task automatic issue(input logic [2:0] op, input logic wr, input logic [6:0] rnid,
                       input logic [5:0] cmt, input logic [3:0] grp,
                       input logic [63:0] a, input logic [63:0] b);
    i_issue_valid    = 1'b1;
    i_issue_op       = op;
    i_issue_wr_valid = wr;
    i_issue_rnid     = rnid;
    i_issue_typ      = 1'b0;
    i_issue_cmt_id   = cmt;
    i_issue_grp_id   = grp;
    i_rs1_data       = a;
    i_rs2_data       = b;
  endtask

  task automatic do_reset();
    tick();
    idle();
    i_reset_n = 1'b0;
    tick();
    tick();
    i_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    i_reset_n = 1'b0;
    #3;
    checks++;
    if ({o_early_wr_valid, o_phy_wr_valid, o_done_valid, o_early_wr_may_mispred} !== 4'b0 ||
        o_phy_wr_data !== 64'd0 || o_kill_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: early=%0b phy=%0b done=%0b data=%h kcnt=%0d, want all 0",
               o_early_wr_valid, o_phy_wr_valid, o_done_valid, o_phy_wr_data, o_kill_cnt);
    end
    tick();
    tick();
    i_reset_n = 1'b1;
  endtask

  task automatic test_add();
    tick(); idle(); issue(3'd0, 1'b1, 7'h12, 6'd1, 4'h1, 64'd5, 64'd7); #1;
    checks++;
    if (o_early_wr_valid !== 1'b0) begin
      errors++; $display("FAIL add_early_T: got %0b want 0", o_early_wr_valid);
    end
    tick(); idle(); #1;
    checks++;
    if (o_early_wr_valid !== 1'b1 || o_early_wr_rnid !== 7'h12 || o_phy_wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_early_T1: got v=%0b rnid=%h phy=%0b want v=1 rnid=12 phy=0",
               o_early_wr_valid, o_early_wr_rnid, o_phy_wr_valid);
    end
    tick(); #1;
    checks++;
    if (o_early_wr_valid !== 1'b0 || o_phy_wr_valid !== 1'b0 || o_done_valid !== 1'b0) begin
      errors++; $display("FAIL add_T2: got early=%0b phy=%0b done=%0b want 0 0 0",
                         o_early_wr_valid, o_phy_wr_valid, o_done_valid);
    end
    tick(); #1;
    checks++;
    if (o_phy_wr_valid !== 1'b1 || o_phy_wr_data !== 64'd12 || o_phy_wr_rnid !== 7'h12 ||
        o_done_valid !== 1'b1 || o_done_cmt_id !== 6'd1) begin
      errors++;
      $display("FAIL add_phy_T3: got v=%0b data=%0d rnid=%h done=%0b cmt=%0d want 1 12 12 1 1",
               o_phy_wr_valid, o_phy_wr_data, o_phy_wr_rnid, o_done_valid, o_done_cmt_id);
    end
    tick(); #1;
    checks++;
    if (o_phy_wr_valid !== 1'b0 || o_done_valid !== 1'b0) begin
      errors++; $display("FAIL add_T4: got phy=%0b done=%0b want 0 0",
                         o_phy_wr_valid, o_done_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_data [3];
    exp_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_data[1] = 64'd1;
    exp_data[2] = 64'd1;
    tick(); idle(); issue(3'd1, 1'b1, 7'h01, 6'd2, 4'h1, 64'd0, 64'd1); #1;
    tick(); idle(); issue(3'd7, 1'b1, 7'h02, 6'd3, 4'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0); #1;
    checks++;
    if (o_early_wr_valid !== 1'b1 || o_early_wr_rnid !== 7'h01) begin
      errors++; $display("FAIL b2b_early0: got v=%0b rnid=%h want 1 01",
                         o_early_wr_valid, o_early_wr_rnid);
    end
    tick(); idle(); issue(3'd6, 1'b1, 7'h03, 6'd4, 4'h1, 64'h8000_0000_0000_0000, 64'd63); #1;
    tick(); idle(); #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        tick(); #1;
      end
      checks++;
      if (o_phy_wr_valid !== 1'b1 || o_phy_wr_data !== exp_data[i] ||
          o_phy_wr_rnid !== 7'(i + 1)) begin
        errors++;
        $display("FAIL b2b_phy%0d: got v=%0b data=%h rnid=%h want 1 %h %h", i,
                 o_phy_wr_valid, o_phy_wr_data, o_phy_wr_rnid, exp_data[i], 7'(i + 1));
      end
    end
  endtask

  task automatic test_no_dest();
    tick(); idle(); issue(3'd0, 1'b0, 7'h44, 6'd3, 4'h2, 64'd1, 64'd2); #1;
    tick(); idle(); #1;
    checks++;
    if (o_early_wr_valid !== 1'b0) begin
      errors++; $display("FAIL nodest_early: got %0b want 0", o_early_wr_valid);
    end
    tick(); #1;
    tick(); #1;
    checks++;
    if (o_phy_wr_valid !== 1'b0 || o_done_valid !== 1'b1 || o_done_cmt_id !== 6'd3 ||
        o_done_grp_id !== 4'h2) begin
      errors++; $display("FAIL nodest_done: got phy=%0b done=%0b cmt=%0d grp=%h want 0 1 3 2",
                         o_phy_wr_valid, o_done_valid, o_done_cmt_id, o_done_grp_id);
    end
  endtask

  task automatic test_branch_wrap();
    do_reset();
    tick(); idle(); issue(3'd0, 1'b1, 7'h21, 6'h21, 4'h1, 64'd1, 64'd1); #1;
    tick(); idle(); issue(3'd0, 1'b1, 7'h1F, 6'h1F, 4'h2, 64'd2, 64'd2); #1;
    tick(); idle();
    i_br_flush = 1'b1; i_br_cmt_id = 6'h1F; i_br_grp_id = 4'h1; #1;
    checks++;
    if (o_early_wr_valid !== 1'b0) begin
      errors++; $display("FAIL brwrap_early: got %0b want 0", o_early_wr_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick(); idle(); #1;
      checks++;
      if (o_phy_wr_valid !== 1'b0 || o_done_valid !== 1'b0) begin
        errors++; $display("FAIL brwrap_nowb%0d: got phy=%0b done=%0b want 0 0", i,
                           o_phy_wr_valid, o_done_valid);
      end
    end
    checks++;
    if (o_kill_cnt !== 16'd2) begin
      errors++; $display("FAIL brwrap_kcnt: got %0d want 2", o_kill_cnt);
    end
  endtask

  task automatic test_grp_boundary();
    do_reset();
    tick(); idle(); issue(3'd0, 1'b1, 7'h31, 6'd4, 4'h1, 64'd1, 64'd1); #1;
    tick(); idle(); issue(3'd0, 1'b1, 7'h32, 6'd4, 4'h4, 64'd3, 64'd3); #1;
    tick(); idle(); issue(3'd4, 1'b1, 7'h33, 6'd3, 4'h8, 64'hF0, 64'hFF);
    i_br_flush = 1'b1; i_br_cmt_id = 6'd4; i_br_grp_id = 4'h2; #1;
    checks++;
    if (o_early_wr_valid !== 1'b0) begin
      errors++; $display("FAIL grp_early_killed: got %0b want 0", o_early_wr_valid);
    end
    tick(); idle(); #1;
    checks++;
    if (o_early_wr_valid !== 1'b1 || o_early_wr_rnid !== 7'h33 || o_phy_wr_valid !== 1'b1 ||
        o_phy_wr_rnid !== 7'h31 || o_phy_wr_data !== 64'd2 || o_done_grp_id !== 4'h1) begin
      errors++;
      $display("FAIL grp_older_survives: got early=%0b/%h phy=%0b/%h/%h grp=%h want 1/33 1/31/2/1",
               o_early_wr_valid, o_early_wr_rnid, o_phy_wr_valid, o_phy_wr_rnid,
               o_phy_wr_data, o_done_grp_id);
    end
    tick(); #1;
    checks++;
    if (o_phy_wr_valid !== 1'b0 || o_done_valid !== 1'b0) begin
      errors++; $display("FAIL grp_younger_killed: got phy=%0b done=%0b want 0 0",
                         o_phy_wr_valid, o_done_valid);
    end
    tick(); #1;
    checks++;
    if (o_phy_wr_valid !== 1'b1 || o_phy_wr_data !== 64'h0F || o_done_cmt_id !== 6'd3 ||
        o_done_grp_id !== 4'h8 || o_kill_cnt !== 16'd1) begin
      errors++;
      $display("FAIL grp_prev_cmt: got v=%0b data=%h cmt=%0d grp=%h kcnt=%0d want 1 0f 3 8 1",
               o_phy_wr_valid, o_phy_wr_data, o_done_cmt_id, o_done_grp_id, o_kill_cnt);
    end
  endtask

  task automatic test_commit_flush();
    do_reset();
    tick(); idle(); issue(3'd0, 1'b1, 7'h51, 6'd10, 4'h1, 64'd1, 64'd1); #1;
    tick(); idle(); issue(3'd0, 1'b1, 7'h52, 6'd11, 4'h1, 64'd1, 64'd1); #1;
    checks++;
    if (o_early_wr_valid !== 1'b1 || o_early_wr_rnid !== 7'h51) begin
      errors++; $display("FAIL cflush_pre_early: got v=%0b rnid=%h want 1 51",
                         o_early_wr_valid, o_early_wr_rnid);
    end
    tick(); idle(); issue(3'd0, 1'b1, 7'h53, 6'd12, 4'h1, 64'd1, 64'd1);
    i_commit_flush = 1'b1; #1;
    checks++;
    if (o_early_wr_valid !== 1'b0) begin
      errors++; $display("FAIL cflush_early: got %0b want 0", o_early_wr_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick(); idle(); #1;
      checks++;
      if (o_early_wr_valid !== 1'b0 || o_phy_wr_valid !== 1'b0 || o_done_valid !== 1'b0) begin
        errors++; $display("FAIL cflush_nowb%0d: got early=%0b phy=%0b done=%0b want 0 0 0", i,
                           o_early_wr_valid, o_phy_wr_valid, o_done_valid);
      end
    end
    checks++;
    if (o_kill_cnt !== 16'd3) begin
      errors++; $display("FAIL cflush_kcnt: got %0d want 3", o_kill_cnt);
    end
    // Reset with an op in flight: everything clears and the op never writes back.
    tick(); idle(); issue(3'd0, 1'b1, 7'h60, 6'd13, 4'h1, 64'd9, 64'd9); #1;
    tick(); idle(); i_reset_n = 1'b0; #1;
    checks++;
    if ({o_early_wr_valid, o_phy_wr_valid, o_done_valid} !== 3'b0 || o_kill_cnt !== 16'd0 ||
        o_phy_wr_data !== 64'd0 || o_early_wr_rnid !== 7'd0) begin
      errors++; $display("FAIL midreset_outputs: early=%0b phy=%0b done=%0b kcnt=%0d want 0",
                         o_early_wr_valid, o_phy_wr_valid, o_done_valid, o_kill_cnt);
    end
    tick();
    i_reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      checks++;
      if (o_phy_wr_valid !== 1'b0 || o_done_valid !== 1'b0) begin
        errors++; $display("FAIL midreset_nowb%0d: got phy=%0b done=%0b want 0 0", i,
                           o_phy_wr_valid, o_done_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_no_dest();
    test_branch_wrap();
    test_grp_boundary();
    test_commit_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
